// File: rtl/spike_input_arbiter_if.sv
// Spike-source and controller-side handshake bundle for spike_input_arbiter.
// The master modport is the arbiter; slave is the sources/controller side.
interface spike_input_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int IW      = 14
);
    logic [NUM_SRC-1:0]    src_req;
    logic [NUM_SRC*IW-1:0] src_index;
    logic [NUM_SRC-1:0]    src_grant;
    logic                  input_occurred;
    logic [IW-1:0]         input_index;
    logic                  input_ack;

    modport master (
        input  src_req,
        input  src_index,
        input  input_ack,
        output src_grant,
        output input_occurred,
        output input_index
    );

    modport slave (
        output src_req,
        output src_index,
        output input_ack,
        input  src_grant,
        input  input_occurred,
        input  input_index
    );
endinterface

// File: rtl/spike_input_arbiter.sv
// Round-robin arbiter funnelling NUM_SRC spike sources into one FIFO feeding network_controller.
// Optional stall counter output enabled by defining SPIKE_ARB_STALL_CNT_EN.
module spike_input_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int SR_DEPTH   = 16384,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    spike_input_arbiter_if.master         bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef SPIKE_ARB_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cycles
`endif
);
    localparam int IW = $clog2(SR_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [IW-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic [NUM_SRC-1:0] grant_reg;
    logic [NUM_SRC-1:0] grant_next;
    logic [RW-1:0]      rr_ptr_reg;
    logic [RW-1:0]      rr_ptr_next;

    logic [IW-1:0]      src_idx [NUM_SRC];
    logic [NUM_SRC-1:0] req_masked;
    logic               win_found;
    logic [RW-1:0]      win_idx;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // A source whose grant is showing this cycle is not yet allowed to win again.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_idx[gi]    = bus.src_index[gi*IW +: IW];
        assign req_masked[gi] = bus.src_req[gi] & ~grant_reg[gi];
    end

    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);

    // Search starts at rr_ptr and wraps; first requester in that order wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!win_found && req_masked[k] &&
                    ((int'(rr_ptr_reg) + i) % NUM_SRC == k)) begin
                    win_found = 1'b1;
                    win_idx   = RW'(k);
                end
            end
        end
    end

    // Eligibility uses the pre-pop count, so a full FIFO never pushes even on an ack edge.
    always_comb begin
        push        = win_found && !fifo_full;
        pop         = bus.input_ack && !fifo_empty;
        grant_next  = '0;
        rr_ptr_next = rr_ptr_reg;
        if (push) begin
            grant_next = NUM_SRC'(1) << win_idx;
            if (int'(win_idx) == NUM_SRC - 1) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = win_idx + RW'(1);
            end
        end
        count_next = count_reg + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= src_idx[win_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg  <= count_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

`ifdef SPIKE_ARB_STALL_CNT_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_reg <= '0;
        end else if ((|bus.src_req) && fifo_full && (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

    // Head is forced to zero while empty so stale array contents never leak after reset.
    assign bus.src_grant      = grant_reg;
    assign bus.input_occurred = !fifo_empty;
    assign bus.input_index    = fifo_empty ? '0 : mem[rd_ptr_reg];
    assign fifo_count         = count_reg;
endmodule

// File: doc/spike_input_arbiter.md
Name: spike_input_arbiter

Overview:
- Shares the single presynaptic-spike port of network_controller (input_occurred / input_index / input_ack) among NUM_SRC spike sources.
- Round-robin grants at most one source request per cycle and buffers granted indices in a FIFO of FIFO_DEPTH entries.
- Presents the FIFO head to the controller and pops on input_ack.
- Sits between spike sources (external AER links, local spike generators) and network_controller.

Parameters:
- NUM_SRC, 4, number of requesting spike sources (>=2).
- SR_DEPTH, 16384, synapse SRAM depth; index width IW = $clog2(SR_DEPTH).
- FIFO_DEPTH, 8, buffered spike entries (power of 2, >=2).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- src_req  input  NUM_SRC  per-source request; held high with stable index until granted.
- src_index  input  NUM_SRC*IW  packed indices; source k occupies bits [k*IW +: IW].
- src_grant  output  NUM_SRC  one-hot registered grant pulse, 1 cycle.
- input_occurred  output  1  FIFO non-empty; drives controller input_occurred.
- input_index  output  IW  FIFO head index.
- input_ack  input  1  controller registered the head spike.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: wr_ptr, rd_ptr and fifo_count = 0; src_grant = 0; input_occurred = 0; input_index = 0; rr_ptr = 0. Reset mid-operation discards all buffered spikes; any in-flight grant is cancelled.
- Arbitration (each cycle): eligible only if fifo_count < FIFO_DEPTH, evaluated on the registered count before this cycle's pop.
  - Search order starts at rr_ptr: rr_ptr, rr_ptr+1, ... wrapping at NUM_SRC.
  - The first k with src_req[k]=1 wins.
  - On the winning edge: push src_index[k], set src_grant[k]=1 for the following cycle, set rr_ptr = (k+1) mod NUM_SRC.
  - With no request or the FIFO full: no grant, rr_ptr holds.
- A source must drop or update its request in the cycle it sees src_grant; the arbiter does not re-grant the same source in the cycle grant is high.
- Output side:
  - input_occurred = (fifo_count != 0).
  - input_index = mem[rd_ptr], driven from the register array (no combinational path from src_*).
  - Push-to-visible latency is 1 cycle: an index pushed at edge t is visible after edge t when the FIFO was empty.
- Pop: at each edge where input_ack=1 and fifo_count != 0, rd_ptr increments and the next head appears after that edge. input_ack with an empty FIFO is ignored.
- Single-pop guarantee: the controller asserts input_ack one cycle after sampling and does not resample until its accumulation pass ends, so one entry is never consumed twice. Pops are strictly one per ack pulse.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance. A push in the same edge as a pop from a full FIFO is not allowed (eligibility uses the pre-pop count), which costs one cycle of throughput at full.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally; fifo_count saturates neither way by construction.
- Order: FIFO order is grant order, and no spike is ever dropped (backpressure only).

Optional Feature:
- Macro: SPIKE_ARB_STALL_CNT_EN.
- Defined: adds output stall_cycles [15:0], reset 0. It increments by 1 each cycle where |src_req=1 and the FIFO is full (no grant possible), saturates at 16'hFFFF, and clears only on reset.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then src_req=4'b0001 with index 0x0123 -> src_grant=0001 one cycle after the edge; input_occurred=1 and input_index=0x0123 after 1 cycle; ack pulse -> fifo_count=0, input_occurred=0.
- All 4 sources request continuously with distinct indices 10, 11, 12, 13, no ack -> grants in order src0, src1, src2, src3, src0, src1, src2, src3; FIFO fills to 8 and grants stop. With STALL_CNT_EN, stall_cycles counts each further cycle.
- Full FIFO plus one ack -> next cycle no grant; cycle after, a grant resumes at rr_ptr; fifo_count returns to 8.
- rr_ptr=2, requests from src0 and src3 only -> src3 granted first, then src0.
- Push and ack on the same edge with fifo_count=3 -> fifo_count stays 3 and the head advances to the next entry in order.
- Assert reset with 5 entries buffered and a grant pending -> all outputs 0 immediately (asynchronous); after release the first new request is served from src0 search order.
